// File: rtl/gf103_pkg.sv
// Shared constants and types for GF(103) arithmetic blocks.
package gf103_pkg;

  localparam int unsigned Q     = 103;
  localparam int unsigned K     = 14;
  localparam int unsigned MU    = 159;
  localparam int unsigned IN_W  = 13;
  localparam int unsigned OUT_W = 7;

  typedef logic [OUT_W-1:0] residue_t;

endpackage

// File: rtl/barrett_core_103.sv
// Combinational Barrett reduction of a 13-bit operand modulo 103.
module barrett_core_103
  import gf103_pkg::*;
(
  input  logic [IN_W-1:0] din_a,
  output residue_t        r
);

  localparam logic [20:0] MuW = 21'(MU);
  localparam logic [13:0] QW  = 14'(Q);
  localparam logic [7:0]  Q8  = 8'(Q);

  logic [20:0] p;
  logic [6:0]  qh;
  logic [7:0]  t8;
  logic [7:0]  r0;

  always_comb begin
    p  = 21'(din_a) * MuW;
    qh = 7'(p >> K);
    // True a - qh*Q lies in 0..205, so working modulo 2^8 is exact.
    t8 = 8'(14'(qh) * QW);
    r0 = 8'(din_a) - t8;
    r  = residue_t'((r0 >= Q8) ? (r0 - Q8) : r0);
  end

endmodule

// File: rtl/barrett_reduce_103.sv
// Registered a mod 103 with a valid flag; one-cycle latency, one operand per cycle.
module barrett_reduce_103
  import gf103_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] din_a,
  input  logic            din_valid,
  output logic [OUT_W-1:0] dout_r,
  output logic            dout_valid
);

  residue_t core_r;
  residue_t dout_r_q, dout_r_d;
  logic     dout_valid_q, dout_valid_d;

  barrett_core_103 u_core (
    .din_a (din_a),
    .r     (core_r)
  );

  // Hold on invalid cycles so an X operand never reaches the register.
  always_comb begin
    dout_valid_d = din_valid;
    dout_r_d     = dout_r_q;
    if (din_valid) begin
      dout_r_d = core_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_r_q     <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_r_q     <= dout_r_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout_r     = dout_r_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_barrett_reduce_103.sv
// Directed self-checking bench for barrett_reduce_103.
module tb_barrett_reduce_103;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] din_a;
  logic        din_valid;
  logic [6:0]  dout_r;
  logic        dout_valid;

  int unsigned total  = 0;
  int unsigned passed = 0;

  barrett_reduce_103 dut (
    .clk        (clk),
    .rst        (rst),
    .din_a      (din_a),
    .din_valid  (din_valid),
    .dout_r     (dout_r),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Apply an operand at the falling edge, then sample 1 ns after the next rising edge.
  task automatic step(input logic [12:0] a, input logic v);
    @(negedge clk);
    din_a     = a;
    din_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    din_a     = '0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_r", dout_r, 0);
    check("reset_valid", dout_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    step(13'd5000, 1'b1);
    check("a5000_r", dout_r, 56);
    check("a5000_valid", dout_valid, 1);

    // Valid gating: X-free hold of previous result
    step(13'd77, 1'b0);
    check("gate_valid", dout_valid, 0);
    check("gate_hold", dout_r, 56);
    step(13'bx, 1'b0);
    check("xin_hold", dout_r, 56);

    // Asynchronous reset mid-stream
    step(13'd500, 1'b1);
    check("pre_rst_r", dout_r, 88);
    @(negedge clk);
    din_a     = 13'd1234;
    din_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_r", dout_r, 0);
    check("async_rst_valid", dout_valid, 0);
    @(negedge clk);
    rst       = 1'b0;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_idle_valid", dout_valid, 0);
    check("post_rst_idle_r", dout_r, 0);
    step(13'd500, 1'b1);
    check("post_rst_500", dout_r, 88);
    check("post_rst_500_valid", dout_valid, 1);

    // Correction boundary and upper range
    step(13'd206, 1'b1);  check("a206", dout_r, 0);
    step(13'd103, 1'b1);  check("a103", dout_r, 0);
    step(13'd205, 1'b1);  check("a205", dout_r, 102);
    step(13'd8191, 1'b1); check("a8191", dout_r, 54);
    step(13'd8137, 1'b1); check("a8137", dout_r, 0);

    // Back-to-back
    step(13'd1000, 1'b1); check("b2b_1000", dout_r, 73);
    step(13'd1001, 1'b1); check("b2b_1001", dout_r, 74);
    step(13'd1002, 1'b1); check("b2b_1002", dout_r, 75);
    check("b2b_valid", dout_valid, 1);

    // Low sweep: identity
    for (int i = 0; i <= 102; i++) begin
      step(13'(i), 1'b1);
      check("low_sweep_r", dout_r, i);
      check("low_sweep_valid", dout_valid, 1);
    end

    // Full sweep against a % 103
    for (int i = 0; i < 8192; i++) begin
      step(13'(i), 1'b1);
      check("full_sweep", dout_r, i % 103);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/barrett_reduce_103.md
Name: barrett_reduce_103

Overview:
- Reduces a 13-bit unsigned operand modulo the prime 103 using Barrett reduction.
- Single-cycle registered datapath with a valid flag.
- Used as the modular-reduction stage after a GF(103) multiply or add; the operand is any value below 2^13.
- The result is the canonical residue 0..102.

Parameters:
- Q, 103: modulus (prime).
- IN_W, 13: operand width.
- OUT_W, 7: result width; ceil(log2(Q)).
- K, 14: Barrett shift.
- MU, 159: Barrett constant, floor(2^K / Q).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- din_a  in  13  unsigned operand a, 0..8191.
- din_valid  in  1  operand qualifier, sampled on the rising edge.
- dout_r  out  7  a mod 103, registered.
- dout_valid  out  1  high for one cycle when dout_r holds the result of a valid operand.

Behaviour:
- Reset:
  - rst high (asynchronous assert) forces dout_r=0 and dout_valid=0 immediately.
  - Release is synchronous to the next clk edge.
- Combinational core, evaluated every cycle on din_a:
  - p = din_a * MU, 21 bits.
  - qh = p >> K, 7 bits.
  - t = qh * Q, 14 bits.
  - r0 = din_a - t, 8 bits. Always 0..205, never negative, because qh is either floor(a/Q) or floor(a/Q)-1.
  - Exactly one conditional correction: r = (r0 >= Q) ? r0 - Q : r0.
  - Truncate r to 7 bits.
- Register stage, on each rising clk edge with rst low:
  - dout_valid <= din_valid.
  - If din_valid: dout_r <= r.
  - Else: dout_r holds its previous value.
- Latency and throughput:
  - Latency is 1 cycle: an operand applied before edge n appears after edge n.
  - Throughput is 1 operand per cycle; no backpressure.
- Output range and width rules:
  - dout_r is always in 0..102 and never equals Q.
  - All arithmetic is unsigned.
  - Internal widths must be sized so no intermediate overflows for din_a = 8191: p max 1302369 < 2^21.
- Reset mid-operation: the result in flight is discarded; dout_valid=0 on the first cycle after release unless din_valid is high at that edge.
- X-safety: when din_valid is low, din_a may be X without corrupting dout_r.
- Standalone checks: a directed sweep may tie din_valid high. Each result must then be readable one clock after the operand is applied.

Decomposition:
- Shared package gf103_pkg holds localparams Q=103, K=14, MU=159, IN_W=13, OUT_W=7, plus a typedef residue_t (logic [6:0]).
- One natural sub-module, barrett_core_103: purely combinational; din_a -> r (the multiply, shift, subtract and single correction).
- The top module adds the output register, valid flag and reset.

Test Plan:
- Reset: assert rst mid-stream with din_valid=1, din_a=500 -> dout_r=0 and dout_valid=0 immediately; after release, din_a=500 -> dout_r=88 after one edge.
- Exhaustive low sweep: din_a=0..102 with din_valid=1 -> dout_r equals din_a one cycle later, dout_valid=1 each cycle.
- Correction boundary: din_a=206 (qh=1, r0=103) -> 0; din_a=103 -> 0; din_a=205 -> 102.
- Upper range: din_a=8191 -> 54; din_a=5000 -> 56; din_a=8137 -> 0; full sweep 0..8191 checked against a%103 with no mismatch.
- Valid gating: din_valid=0 with din_a=77, following a valid 5000 -> dout_valid=0 and dout_r holds 56.
- Back-to-back throughput: 1000, 1001, 1002 on consecutive cycles -> 73, 74, 75 on consecutive cycles.
